cam_capture: RTL and testbench

CAM_CAPTURE -- requirements
Module: cam_capture

---
 rtl/cam_pkg.sv | 44 ++++
 rtl/cam_capture_if.sv | 36 +++
 rtl/cam_sync_edge.sv | 37 +++
 rtl/cam_capture.sv | 159 +++++++++++++++
 tb/tb_cam_capture.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cam_pkg.sv
// cam_pkg: shared constants and types for the camera capture block.
//   FRAME_PIXELS / LINE_PIXELS / LINE_COUNT : QQVGA frame geometry.
//   ADDR_W                                  : frame-buffer address width.
//   RED / GREEN / BLUE                      : RGB332 colour constants.
//   cam_state_t                             : capture FSM state encoding.
//   pattern_pixel()                         : colour-bar generator, only when
//                                             CAM_TESTPATTERN_EN is defined.
package cam_pkg;

   localparam int FRAME_PIXELS = 19200;
   localparam int LINE_PIXELS  = 160;
   localparam int LINE_COUNT   = 120;
   localparam int ADDR_W       = 15;

   localparam logic [7:0] RED   = 8'hE0;
   localparam logic [7:0] GREEN = 8'h1C;
   localparam logic [7:0] BLUE  = 8'h03;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WAIT_VS = 3'd1,
      WAIT_FS = 3'd2,
      BYTE_HI = 3'd3,
      BYTE_LO = 3'd4,
      FINISH  = 3'd5
   } cam_state_t;

`ifdef CAM_TESTPATTERN_EN
   // Three vertical bars of roughly equal width across each 160-pixel line.
   localparam int PAT_GREEN_COL = 53;
   localparam int PAT_BLUE_COL  = 106;

   function automatic logic [7:0] pattern_pixel(input logic [ADDR_W-1:0] addr);
      logic [ADDR_W-1:0] col;
      col = addr % ADDR_W'(LINE_PIXELS);
      if (col < ADDR_W'(PAT_GREEN_COL))
         return RED;
      else if (col < ADDR_W'(PAT_BLUE_COL))
         return GREEN;
      return BLUE;
   endfunction
`endif

endpackage

// File: rtl/cam_capture_if.sv
// cam_capture_if: camera pins, start request and frame-buffer write port.
//   init                         : start request (level, sampled each clk).
//   cam_pclk/cam_vsync/cam_href  : raw camera timing, asynchronous to clk.
//   cam_data[7:0]                : RGB565 byte, high byte first.
//   mem_addr/mem_data/mem_we     : frame-buffer write port.
//   done/frame_err               : end-of-capture pulse and sticky short-frame flag.
// Handshake: mem_we is a one-cycle strobe that qualifies mem_addr and
// mem_data in that same cycle. There is no ready/backpressure; the frame
// buffer must accept every strobed write. done is a one-cycle pulse and
// frame_err is valid whenever done is high.
// Modports: slave = capture block, master = camera/buffer side.
interface cam_capture_if;
   import cam_pkg::*;

   logic              init;
   logic              cam_pclk;
   logic              cam_vsync;
   logic              cam_href;
   logic [7:0]        cam_data;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_data;
   logic              mem_we;
   logic              done;
   logic              frame_err;

   modport slave (
      input  init, cam_pclk, cam_vsync, cam_href, cam_data,
      output mem_addr, mem_data, mem_we, done, frame_err
   );

   modport master (
      output init, cam_pclk, cam_vsync, cam_href, cam_data,
      input  mem_addr, mem_data, mem_we, done, frame_err
   );

endinterface

// File: rtl/cam_sync_edge.sv
// cam_sync_edge: STAGES-deep synchronizer for one asynchronous bit with
// rise/fall detection on the synchronized level.
//   clk, rst (async, active-low)
//   din  : asynchronous input
//   lvl  : synchronized level
//   rise : one-cycle pulse when lvl goes 0->1
//   fall : one-cycle pulse when lvl goes 1->0
module cam_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic lvl,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   // The cast drops the oldest bit, so this works for any STAGES >= 1.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= STAGES'({sync_q, din});
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign lvl  = sync_q[STAGES-1];
   assign rise = lvl & ~prev_q;
   assign fall = ~lvl & prev_q;

endmodule

// File: rtl/cam_capture.sv
// cam_capture: captures one RGB565 frame from a parallel camera, converts
// each pixel to RGB332 and writes it to a frame buffer, then pulses done.
//   clk        : system clock (rising edge)
//   rst        : asynchronous active-low reset
//   bus        : cam_capture_if.slave (init, camera pins, write port, done, frame_err)
//   fsm_state  : current capture state, for observation
// Build option: CAM_TESTPATTERN_EN replaces camera colour with vertical
// colour bars while keeping the camera's pixel timing.
module cam_capture #(
   parameter int FRAME_PIXELS = cam_pkg::FRAME_PIXELS,
   parameter int SYNC_STAGES  = 2
) (
   input  logic                clk,
   input  logic                rst,
   cam_capture_if.slave        bus,
   output cam_pkg::cam_state_t fsm_state
);
   import cam_pkg::*;

   // Camera input synchronization
   logic pclk_lvl, pclk_rise, pclk_fall;
   logic vs_lvl, vs_rise, vs_fall;
   logic href_lvl, href_rise, href_fall;
   logic unused_sync;

   cam_sync_edge #(.STAGES(SYNC_STAGES)) u_pclk_sync (
      .clk(clk), .rst(rst), .din(bus.cam_pclk),
      .lvl(pclk_lvl), .rise(pclk_rise), .fall(pclk_fall));
   cam_sync_edge #(.STAGES(SYNC_STAGES)) u_vsync_sync (
      .clk(clk), .rst(rst), .din(bus.cam_vsync),
      .lvl(vs_lvl), .rise(vs_rise), .fall(vs_fall));
   cam_sync_edge #(.STAGES(SYNC_STAGES)) u_href_sync (
      .clk(clk), .rst(rst), .din(bus.cam_href),
      .lvl(href_lvl), .rise(href_rise), .fall(href_fall));

   assign unused_sync = &{1'b0, pclk_lvl, pclk_fall, href_rise, href_fall};

   // Data goes through the same depth as pclk so the byte lines up with
   // the detected pclk rising edge.
   logic [7:0] data_sync_q [SYNC_STAGES];
   logic [7:0] byte_s;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) data_sync_q[i] <= '0;
      end else begin
         data_sync_q[0] <= bus.cam_data;
         for (int i = 1; i < SYNC_STAGES; i++) data_sync_q[i] <= data_sync_q[i-1];
      end
   end

   assign byte_s = data_sync_q[SYNC_STAGES-1];

   // Capture FSM
   cam_state_t        state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [2:0]        r_q, r_d, g_q, g_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        data_q, data_d;
   logic              we_q, we_d, done_q, done_d, err_q, err_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         r_q     <= '0;
         g_q     <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         we_q    <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         r_q     <= r_d;
         g_q     <= g_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         we_q    <= we_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      r_d     = r_q;
      g_d     = g_q;
      addr_d  = addr_q;
      data_d  = data_q;
      we_d    = 1'b0;
      done_d  = 1'b0;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (bus.init) begin
               state_d = WAIT_VS;
               err_d   = 1'b0;
            end
         end
         WAIT_VS: begin
            if (vs_lvl) state_d = WAIT_FS;
         end
         WAIT_FS: begin
            if (vs_fall) begin
               state_d = BYTE_HI;
               cnt_d   = '0;
            end
         end
         BYTE_HI: begin
            // The count is always below FRAME_PIXELS here: reaching it leaves
            // for FINISH, so a vsync rise in a byte state is always short.
            if (vs_rise) begin
               err_d   = 1'b1;
               state_d = FINISH;
            end else if (pclk_rise && href_lvl) begin
               r_d     = byte_s[7:5];
               g_d     = byte_s[2:0];
               state_d = BYTE_LO;
            end
         end
         BYTE_LO: begin
            if (vs_rise) begin
               err_d   = 1'b1;
               state_d = FINISH;
            end else if (!href_lvl) begin
               // Line ended after an odd high byte: drop it, no write.
               state_d = BYTE_HI;
            end else if (pclk_rise) begin
               we_d   = 1'b1;
               addr_d = cnt_q;
`ifdef CAM_TESTPATTERN_EN
               data_d = pattern_pixel(cnt_q);
`else
               data_d = {r_q, g_q, byte_s[4:3]};
`endif
               cnt_d  = cnt_q + ADDR_W'(1);
               if (cnt_q == ADDR_W'(FRAME_PIXELS - 1)) state_d = FINISH;
               else                                    state_d = BYTE_HI;
            end
         end
         FINISH: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.mem_addr  = addr_q;
   assign bus.mem_data  = data_q;
   assign bus.mem_we    = we_q;
   assign bus.done      = done_q;
   assign bus.frame_err = err_q;
   assign fsm_state     = state_q;

endmodule

// File: tb/tb_cam_capture.sv
`timescale 1ns/1ps
module tb_cam_capture;
   import cam_pkg::*;

   localparam int FP     = 19200;
   localparam int SYNC   = 2;
   localparam int EXTRA  = 40;
   localparam int RST_AT = 500;
`ifdef CAM_TESTPATTERN_EN
   localparam bit USE_PATTERN = 1'b1;
`else
   localparam bit USE_PATTERN = 1'b0;
`endif

   // Clock / reset
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   cam_capture_if bus();
   cam_state_t    fsm_state;

   cam_capture #(.FRAME_PIXELS(FP), .SYNC_STAGES(SYNC)) dut (
      .clk(clk), .rst(rst), .bus(bus), .fsm_state(fsm_state));

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: expected writes from the model, observed writes from the monitor
   logic [22:0] exp_q[$];
   int          lat_q[$];
   logic [22:0] got_q[$];
   int          got_cyc_q[$];
   int          done_cnt = 0;
   logic        err_at_done = 1'b0;
   bit          capturing = 1'b0;
   int          exp_idx = 0;
   int          line_pos = 0;

   always @(negedge clk) begin
      if (bus.mem_we) begin
         got_q.push_back({bus.mem_addr, bus.mem_data});
         got_cyc_q.push_back(cyc);
      end
      if (bus.done) begin
         done_cnt++;
         err_at_done = bus.frame_err;
      end
   end

   // Reference model: RGB565 -> RGB332 keeps the top bits of each channel.
   function automatic logic [7:0] model_pixel(input logic [7:0] hi, input logic [7:0] lo, input int idx);
      logic [15:0] rgb565;
      logic [7:0]  cam_px, pat_px;
      int          col;
      rgb565 = {hi, lo};
      cam_px = {rgb565[15:13], rgb565[10:8], rgb565[4:3]};
      col    = idx % LINE_PIXELS;
      pat_px = (col < 53) ? RED : (col < 106) ? GREEN : BLUE;
      return USE_PATTERN ? pat_px : cam_px;
   endfunction

   // Driver tasks
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_sb();
      exp_q.delete(); lat_q.delete(); got_q.delete(); got_cyc_q.delete();
      done_cnt = 0; err_at_done = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.cam_data = b;
      bus.cam_pclk = 1'b1;
      tick(1);
      bus.cam_pclk = 1'b0;
      tick(1);
   endtask

   task automatic send_pixel(input logic [7:0] hi, input logic [7:0] lo);
      int stamp;
      if (line_pos == LINE_PIXELS) begin
         bus.cam_href = 1'b0; tick(2); bus.cam_href = 1'b1; line_pos = 0;
      end
      send_byte(hi);
      stamp = cyc + 1;  // posedge that samples the low byte
      send_byte(lo);
      line_pos++;
      if (capturing && exp_idx < FP) begin
         exp_q.push_back({15'(exp_idx), model_pixel(hi, lo, exp_idx)});
         lat_q.push_back(stamp);
         exp_idx++;
      end
   endtask

   task automatic start_frame();
      bus.init = 1'b1; tick(1); bus.init = 1'b0;
      bus.cam_vsync = 1'b1; tick(2*SYNC+4);
      bus.cam_vsync = 1'b0; tick(2*SYNC+4);
      capturing = 1'b1; exp_idx = 0; line_pos = 0;
      bus.cam_href = 1'b1; tick(1);
   endtask

   task automatic end_frame();
      bus.cam_href = 1'b0; tick(2);
      bus.cam_vsync = 1'b1; tick(2*SYNC+6);
      bus.cam_vsync = 1'b0; tick(2*SYNC+4);
      capturing = 1'b0;
   endtask

   // Tests
   task automatic test_reset();
      tick(3);
      checks++;
      if ({bus.mem_addr, bus.mem_data, bus.mem_we, bus.done, bus.frame_err} !== 26'd0) begin
         failures++;
         $display("FAIL reset_outputs: got addr=%0d data=%h we=%b done=%b err=%b, expected all 0",
                  bus.mem_addr, bus.mem_data, bus.mem_we, bus.done, bus.frame_err);
      end
      checks++;
      if (fsm_state !== IDLE) begin
         failures++; $display("FAIL reset_state: got %0d, expected IDLE", fsm_state);
      end
      rst = 1'b1;
      tick(2);
   endtask

   task automatic test_colors();
      clear_sb();
      start_frame();
      send_pixel(8'hF8, 8'h00);
      send_pixel(8'h07, 8'hE0);
      send_pixel(8'h00, 8'h1F);
      repeat (20) send_pixel(8'($urandom), 8'($urandom));
      end_frame();
      checks++;
      if (got_q.size() != exp_q.size()) begin
         failures++; $display("FAIL colors_count: got %0d writes, expected %0d", got_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < got_q.size()) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL colors_write %0d: got addr=%0d data=%h, expected addr=%0d data=%h",
                     i, got_q[i][22:8], got_q[i][7:0], exp_q[i][22:8], exp_q[i][7:0]);
         end
         checks++;
         if (got_cyc_q[i] - lat_q[i] > SYNC + 2 || got_cyc_q[i] - lat_q[i] < 1) begin
            failures++;
            $display("FAIL colors_latency %0d: got %0d cycles, expected 1..%0d", i, got_cyc_q[i] - lat_q[i], SYNC + 2);
         end
      end
      checks++;
      if (done_cnt != 1 || err_at_done !== 1'b1) begin
         failures++; $display("FAIL colors_done: got done=%0d err=%b, expected done=1 err=1", done_cnt, err_at_done);
      end
   endtask

   task automatic test_short_frame();
      clear_sb();
      start_frame();
      checks++;
      if (bus.frame_err !== 1'b0) begin
         failures++; $display("FAIL short_err_clear: got %b, expected 0 after init", bus.frame_err);
      end
      repeat (100) send_pixel(8'($urandom), 8'($urandom));
      end_frame();
      checks++;
      if (got_q.size() != 100) begin
         failures++; $display("FAIL short_count: got %0d writes, expected 100", got_q.size());
      end
      foreach (exp_q[i]) if (i < got_q.size()) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL short_write %0d: got addr=%0d data=%h, expected addr=%0d data=%h",
                     i, got_q[i][22:8], got_q[i][7:0], exp_q[i][22:8], exp_q[i][7:0]);
         end
      end
      checks++;
      if (done_cnt != 1 || err_at_done !== 1'b1) begin
         failures++; $display("FAIL short_done: got done=%0d err=%b, expected done=1 err=1", done_cnt, err_at_done);
      end
   endtask

   task automatic test_href_drop();
      clear_sb();
      start_frame();
      checks++;
      if (bus.frame_err !== 1'b0) begin
         failures++; $display("FAIL href_err_clear: got %b, expected 0 after init", bus.frame_err);
      end
      repeat (3) send_pixel(8'($urandom), 8'($urandom));
      send_byte(8'($urandom));  // lone high byte, line ends here
      bus.cam_href = 1'b0; tick(2*SYNC+2);
      bus.cam_href = 1'b1; tick(1);
      repeat (3) send_pixel(8'($urandom), 8'($urandom));
      end_frame();
      checks++;
      if (got_q.size() != 6) begin
         failures++; $display("FAIL href_count: got %0d writes, expected 6", got_q.size());
      end
      foreach (exp_q[i]) if (i < got_q.size()) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL href_write %0d: got addr=%0d data=%h, expected addr=%0d data=%h",
                     i, got_q[i][22:8], got_q[i][7:0], exp_q[i][22:8], exp_q[i][7:0]);
         end
      end
   endtask

   task automatic test_full_frame();
      clear_sb();
      start_frame();
      for (int p = 0; p < FP + EXTRA; p++) begin
         if (p == FP / 2) begin
            bus.init = 1'b1; tick(1); bus.init = 1'b0;
         end
         send_pixel(8'hF8, 8'h00);
      end
      end_frame();
      checks++;
      if (got_q.size() != FP) begin
         failures++; $display("FAIL full_count: got %0d writes, expected %0d", got_q.size(), FP);
      end
      foreach (exp_q[i]) if (i < got_q.size()) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL full_write %0d: got addr=%0d data=%h, expected addr=%0d data=%h",
                     i, got_q[i][22:8], got_q[i][7:0], exp_q[i][22:8], exp_q[i][7:0]);
         end
      end
      checks++;
      if (done_cnt != 1 || err_at_done !== 1'b0) begin
         failures++; $display("FAIL full_done: got done=%0d err=%b, expected done=1 err=0", done_cnt, err_at_done);
      end
      checks++;
      if (fsm_state !== IDLE || bus.mem_addr !== 15'(FP - 1)) begin
         failures++; $display("FAIL full_idle: got state=%0d addr=%0d, expected IDLE addr=%0d", fsm_state, bus.mem_addr, FP - 1);
      end
   endtask

   task automatic test_reset_mid_frame();
      clear_sb();
      start_frame();
      repeat (RST_AT) send_pixel(8'($urandom), 8'($urandom));
      send_byte(8'($urandom));
      tick(1);
      rst = 1'b0;
      capturing = 1'b0;
      #1;
      checks++;
      if ({bus.mem_addr, bus.mem_data, bus.mem_we, bus.done, bus.frame_err} !== 26'd0 || fsm_state !== IDLE) begin
         failures++;
         $display("FAIL midrst_outputs: got addr=%0d data=%h we=%b done=%b err=%b state=%0d, expected all 0 and IDLE",
                  bus.mem_addr, bus.mem_data, bus.mem_we, bus.done, bus.frame_err, fsm_state);
      end
      tick(3);
      rst = 1'b1;
      tick(2);
      repeat (20) send_pixel(8'($urandom), 8'($urandom));
      end_frame();                 // vsync cycle without init
      bus.cam_href = 1'b1; line_pos = 0;
      repeat (20) send_pixel(8'($urandom), 8'($urandom));
      bus.cam_href = 1'b0; tick(2);
      checks++;
      if (got_q.size() != RST_AT) begin
         failures++; $display("FAIL midrst_idle_writes: got %0d writes, expected %0d", got_q.size(), RST_AT);
      end
      start_frame();
      repeat (LINE_PIXELS) send_pixel(8'($urandom), 8'($urandom));
      end_frame();
      checks++;
      if (got_q.size() != exp_q.size()) begin
         failures++; $display("FAIL midrst_count: got %0d writes, expected %0d", got_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < got_q.size()) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL midrst_write %0d: got addr=%0d data=%h, expected addr=%0d data=%h",
                     i, got_q[i][22:8], got_q[i][7:0], exp_q[i][22:8], exp_q[i][7:0]);
         end
      end
      checks++;
      if (done_cnt != 1) begin
         failures++; $display("FAIL midrst_done: got %0d done pulses, expected 1", done_cnt);
      end
   endtask

   initial begin
      #(10 * 120000);
      failures++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.init      = 1'b0;
      bus.cam_pclk  = 1'b0;
      bus.cam_vsync = 1'b0;
      bus.cam_href  = 1'b0;
      bus.cam_data  = 8'h00;
      test_reset();
      test_colors();
      test_short_frame();
      test_href_drop();
      test_full_frame();
      test_reset_mid_frame();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
